// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory-access stage of the 5-stage MIPS pipeline. Loads and
//                stores run over a synchronous req/ack bus while the pipeline
//                is stalled. Non-memory instructions pass straight through to
//                mem_wb in the same cycle. Loaded data is lane-selected
//                (big-endian) and sign/zero-extended before writeback.
//  Options     : MEM_ALIGN_CHECK_EN - when defined, misaligned half/word
//                accesses skip the bus and pulse align_err_o in DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_wdata_o,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        align_err_o,
`endif
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  // Operation encodings on mem_op_i
  localparam logic [3:0] c_OP_LB  = 4'd1;
  localparam logic [3:0] c_OP_LBU = 4'd2;
  localparam logic [3:0] c_OP_LH  = 4'd3;
  localparam logic [3:0] c_OP_LHU = 4'd4;
  localparam logic [3:0] c_OP_LW  = 4'd5;
  localparam logic [3:0] c_OP_SB  = 4'd6;
  localparam logic [3:0] c_OP_SH  = 4'd7;
  localparam logic [3:0] c_OP_SW  = 4'd8;

  // The wait counter is 8 bits; a zero limit disables the abort entirely
  localparam logic [7:0] c_TIMEOUT    = 8'(TIMEOUT);
  localparam bit         c_TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_wd;
  logic [3:0]  r_op;
  logic [1:0]  r_addr_lo;
  logic        r_is_load;
  logic        r_wreg_done;
  logic [31:0] r_result;
  logic [7:0]  r_cnt;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_sel;
  logic [31:0] r_mem_wdata;
  logic        r_bus_err;
`ifdef MEM_ALIGN_CHECK_EN
  logic        r_align_err;
`endif

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic        w_misaligned;
  logic [3:0]  w_sel;
  logic [31:0] w_store_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [7:0]  w_cnt_inc;
  logic        w_timeout;

  // Classify the incoming operation; unknown codes behave like "none"
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    case (mem_op_i)
      c_OP_LB, c_OP_LBU, c_OP_LH, c_OP_LHU, c_OP_LW: w_is_load  = 1'b1;
      c_OP_SB, c_OP_SH, c_OP_SW:                     w_is_store = 1'b1;
      default: ;
    endcase
    w_is_mem = w_is_load | w_is_store;
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Half accesses must be 2-byte aligned, word accesses 4-byte aligned
  always_comb begin
    w_misaligned = 1'b0;
    case (mem_op_i)
      c_OP_LH, c_OP_LHU, c_OP_SH: w_misaligned = mem_addr_i[0];
      c_OP_LW, c_OP_SW:           w_misaligned = |mem_addr_i[1:0];
      default: ;
    endcase
  end
`else
  // Without the check, low address bits are simply ignored for half/word
  assign w_misaligned = 1'b0;
`endif

  // Byte-lane select and lane-replicated store data (lane 3 = bits 31:24)
  always_comb begin
    w_sel        = 4'b0000;
    w_store_data = 32'h0000_0000;
    case (mem_op_i)
      c_OP_LB, c_OP_LBU, c_OP_SB: w_sel = 4'b1000 >> mem_addr_i[1:0];
      c_OP_LH, c_OP_LHU, c_OP_SH: w_sel = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      c_OP_LW, c_OP_SW:           w_sel = 4'b1111;
      default: ;
    endcase
    case (mem_op_i)
      c_OP_SB: w_store_data = {4{reg2_i[7:0]}};
      c_OP_SH: w_store_data = {2{reg2_i[15:0]}};
      c_OP_SW: w_store_data = reg2_i;
      default: ;
    endcase
  end

  // Format returning read data from the latched op and address offset
  always_comb begin
    w_byte      = 8'h00;
    w_load_data = mem_rdata_i;
    case (r_addr_lo)
      2'b00:   w_byte = mem_rdata_i[31:24];
      2'b01:   w_byte = mem_rdata_i[23:16];
      2'b10:   w_byte = mem_rdata_i[15:8];
      default: w_byte = mem_rdata_i[7:0];
    endcase
    w_half = r_addr_lo[1] ? mem_rdata_i[15:0] : mem_rdata_i[31:16];
    case (r_op)
      c_OP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      c_OP_LBU: w_load_data = {24'h00_0000, w_byte};
      c_OP_LH:  w_load_data = {{16{w_half[15]}}, w_half};
      c_OP_LHU: w_load_data = {16'h0000, w_half};
      default:  w_load_data = mem_rdata_i;
    endcase
  end

  // Abort fires on the BUSY cycle that brings the count up to the limit
  always_comb begin
    w_cnt_inc = r_cnt + 8'd1;
    w_timeout = c_TIMEOUT_EN && (w_cnt_inc == c_TIMEOUT);
  end

  // Transaction state machine with registered bus-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wd        <= 5'd0;
      r_op        <= 4'd0;
      r_addr_lo   <= 2'd0;
      r_is_load   <= 1'b0;
      r_wreg_done <= 1'b0;
      r_result    <= 32'h0000_0000;
      r_cnt       <= 8'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_sel   <= 4'b0000;
      r_mem_wdata <= 32'h0000_0000;
      r_bus_err   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      r_align_err <= 1'b0;
`endif
    end else begin
      // Error flags are single-cycle pulses
      r_bus_err <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      r_align_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_is_mem) begin
            // Capture everything needed later; upstream may not be trusted
            // to hold its outputs while the bus is in flight
            r_wd        <= wd_i;
            r_op        <= mem_op_i;
            r_addr_lo   <= mem_addr_i[1:0];
            r_is_load   <= w_is_load;
            r_wreg_done <= 1'b0;
            r_result    <= wdata_i;
            if (w_misaligned) begin
              r_state <= S_DONE;
`ifdef MEM_ALIGN_CHECK_EN
              r_align_err <= 1'b1;
`endif
            end else begin
              r_state     <= S_BUSY;
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_is_store;
              r_mem_addr  <= {mem_addr_i[31:2], 2'b00};
              r_mem_sel   <= w_sel;
              r_mem_wdata <= w_store_data;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= w_cnt_inc;
          if (mem_ack_i) begin
            r_mem_req <= 1'b0;
            r_state   <= S_DONE;
            if (r_is_load) begin
              r_result    <= w_load_data;
              r_wreg_done <= 1'b1;
            end
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= 8'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Writeback mux: passthrough in IDLE, latched results otherwise
  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stallreq_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_mem) begin
          stallreq_o = 1'b1;
          wreg_o     = 1'b0;
        end
      end
      S_BUSY: begin
        wd_o       = r_wd;
        wreg_o     = 1'b0;
        wdata_o    = r_result;
        stallreq_o = 1'b1;
      end
      S_DONE: begin
        wd_o    = r_wd;
        wreg_o  = r_wreg_done;
        wdata_o = r_result;
      end
      default: ;
    endcase
  end

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_sel_o   = r_mem_sel;
  assign mem_wdata_o = r_mem_wdata;
  assign bus_err_o   = r_bus_err;
`ifdef MEM_ALIGN_CHECK_EN
  assign align_err_o = r_align_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage. Transactions are described
//                at the instruction level; expected per-cycle outputs come from
//                a small arithmetic model and are compared every cycle.
//  Options     : MEM_ALIGN_CHECK_EN - also exercises align_err_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic        bus_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err_o;
`endif

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .mem_op_i    (mem_op_i),
    .mem_addr_i  (mem_addr_i),
    .reg2_i      (reg2_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stallreq_o  (stallreq_o),
    .bus_err_o   (bus_err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_sel_o   (mem_sel_o),
    .mem_wdata_o (mem_wdata_o),
`ifdef MEM_ALIGN_CHECK_EN
    .align_err_o (align_err_o),
`endif
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected outputs for the current cycle
  bit          e_on = 1'b0;
  bit          e_stall, e_wreg, e_req, e_err;
  bit          e_pass_chk, e_wdata_chk, e_bus_chk, e_bwd_chk, e_we;
  logic [4:0]  e_wd;
  logic [31:0] e_wdata, e_baddr, e_bwdata;
  logic [3:0]  e_sel;
`ifdef MEM_ALIGN_CHECK_EN
  bit          e_aerr;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_is_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic bit m_is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] a);
    int b;
    b = int'(a[1:0]);
    case (op)
      4'd1, 4'd2, 4'd6: return 4'(8 >> b);
      4'd3, 4'd4, 4'd7: return a[1] ? 4'b0011 : 4'b1100;
      4'd5, 4'd8:       return 4'b1111;
      default:          return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [3:0] op, input logic [31:0] r);
    case (op)
      4'd6:    return {24'd0, r[7:0]} * 32'h0101_0101;
      4'd7:    return {16'd0, r[15:0]} * 32'h0001_0001;
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    int b, h;
    logic [31:0] byt, hw;
    b = int'(a[1:0]);
    h = int'(a[1]);
    byt = (rd >> (8 * (3 - b))) & 32'h0000_00FF;
    hw  = (rd >> (16 * (1 - h))) & 32'h0000_FFFF;
    case (op)
      4'd1:    return byt[7]  ? (byt | 32'hFFFF_FF00) : byt;
      4'd2:    return byt;
      4'd3:    return hw[15]  ? (hw | 32'hFFFF_0000) : hw;
      4'd4:    return hw;
      default: return rd;
    endcase
  endfunction

  function automatic bit m_misaligned(input logic [3:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    if ((op == 4'd3 || op == 4'd4 || op == 4'd7) && (a % 2 != 0)) return 1'b1;
    if ((op == 4'd5 || op == 4'd8) && (a % 4 != 0)) return 1'b1;
`endif
    return (op == 4'd15) && (a == 32'hFFFF_FFFF) && 1'b0;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (e_on) begin
      chk("stallreq_o", 32'(stallreq_o), 32'(e_stall));
      chk("wreg_o",     32'(wreg_o),     32'(e_wreg));
      chk("mem_req_o",  32'(mem_req_o),  32'(e_req));
      chk("bus_err_o",  32'(bus_err_o),  32'(e_err));
`ifdef MEM_ALIGN_CHECK_EN
      chk("align_err_o", 32'(align_err_o), 32'(e_aerr));
`endif
      if (e_pass_chk)  chk("wd_o",    32'(wd_o), 32'(e_wd));
      if (e_wdata_chk) chk("wdata_o", wdata_o, e_wdata);
      if (e_bus_chk) begin
        chk("mem_addr_o", mem_addr_o,      e_baddr);
        chk("mem_sel_o",  32'(mem_sel_o),  32'(e_sel));
        chk("mem_we_o",   32'(mem_we_o),   32'(e_we));
      end
      if (e_bwd_chk) chk("mem_wdata_o", mem_wdata_o, e_bwdata);
    end
  end

  task automatic clr_exp();
    e_stall = 1'b0; e_wreg = 1'b0; e_req = 1'b0; e_err = 1'b0;
    e_pass_chk = 1'b0; e_wdata_chk = 1'b0; e_bus_chk = 1'b0; e_bwd_chk = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    e_aerr = 1'b0;
`endif
  endtask

  // One IDLE cycle with a non-memory op; optional stray ack must be ignored
  task automatic do_pass(input logic [4:0] wd, input bit wr, input logic [31:0] wdat,
                         input logic [3:0] op, input bit stray);
    @(posedge clk); #1;
    mem_op_i = op; wd_i = wd; wreg_i = wr; wdata_i = wdat;
    mem_addr_i = $urandom; reg2_i = $urandom;
    mem_ack_i = stray; mem_rdata_i = $urandom;
    clr_exp();
    e_on = 1'b1;
    e_pass_chk = 1'b1; e_wd = wd; e_wreg = wr;
    e_wdata_chk = 1'b1; e_wdata = wdat;
  endtask

  // Full memory instruction: IDLE, BUSY (ack on cycle ack_at, 0 = never), DONE
  task automatic do_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] wdat, input logic [4:0] wd, input int ack_at,
                        input logic [31:0] rdata, input bit lit, input logic [31:0] l_res,
                        input logic [3:0] l_sel, input logic [31:0] l_baddr,
                        input logic [31:0] l_bwd);
    bit          ld, mis, abort;
    logic [3:0]  sel;
    logic [31:0] bwd, res, baddr;
    int          nbusy;
    ld    = m_is_load(op);
    mis   = m_misaligned(op, addr);
    sel   = m_sel(op, addr);
    bwd   = m_store(op, reg2);
    res   = ld ? m_load(op, addr, rdata) : wdat;
    baddr = addr & 32'hFFFF_FFFC;
    if (lit) begin
      chk("model_result", res, l_res);
      chk("model_sel", 32'(sel), 32'(l_sel));
      chk("model_addr", baddr, l_baddr);
      if (!ld) chk("model_wdata", bwd, l_bwd);
    end
    // IDLE cycle: instruction presented, stall requested at once
    @(posedge clk); #1;
    mem_op_i = op; mem_addr_i = addr; reg2_i = reg2; wdata_i = wdat;
    wd_i = wd; wreg_i = 1'($urandom);
    mem_ack_i = 1'($urandom); mem_rdata_i = $urandom;
    clr_exp();
    e_stall = 1'b1;
    abort = 1'b0;
    if (!mis) begin
      abort = !(ack_at >= 1 && ack_at <= TO);
      nbusy = abort ? TO : ack_at;
      for (int k = 1; k <= nbusy; k++) begin
        @(posedge clk); #1;
        mem_ack_i   = (k == ack_at);
        mem_rdata_i = (k == ack_at) ? rdata : $urandom;
        clr_exp();
        e_stall = 1'b1; e_req = 1'b1;
        e_bus_chk = 1'b1; e_baddr = baddr; e_sel = sel; e_we = !ld;
        e_bwd_chk = !ld; e_bwdata = bwd;
      end
    end
    // DONE cycle: result presented, stray ack ignored
    @(posedge clk); #1;
    mem_ack_i = 1'($urandom); mem_rdata_i = $urandom;
    clr_exp();
    e_err = abort;
`ifdef MEM_ALIGN_CHECK_EN
    e_aerr = mis;
`endif
    e_wreg = ld && !abort && !mis;
    e_pass_chk = 1'b1; e_wd = wd;
    e_wdata_chk = !(ld && (abort || mis)); e_wdata = res;
  endtask

  initial begin
    rst = 1'b1;
    wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'd0; mem_op_i = 4'd0;
    mem_addr_i = 32'd0; reg2_i = 32'd0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    clr_exp();
    @(posedge clk); #1;
    // Reset state: bus fields all zero, passthrough of zero inputs
    e_on = 1'b1;
    e_pass_chk = 1'b1; e_wd = 5'd0; e_wdata_chk = 1'b1; e_wdata = 32'd0;
    e_bus_chk = 1'b1; e_baddr = 32'd0; e_sel = 4'd0; e_we = 1'b0;
    e_bwd_chk = 1'b1; e_bwdata = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    do_pass(5'd3, 1'b1, 32'h0000_1234, 4'd0, 1'b0);
    do_pass(5'd9, 1'b0, 32'hDEAD_BEEF, 4'd12, 1'b1);
    do_mem(4'd1, 32'h0000_0101, 32'h1, 32'h2, 5'd5, 1, 32'h11F2_3344,
           1'b1, 32'hFFFF_FFF2, 4'b0100, 32'h0000_0100, 32'h0);
    do_mem(4'd2, 32'h0000_0101, 32'h1, 32'h2, 5'd6, 1, 32'h11F2_3344,
           1'b1, 32'h0000_00F2, 4'b0100, 32'h0000_0100, 32'h0);
    do_mem(4'd7, 32'h0000_0202, 32'hAAAA_5678, 32'hCAFE_0001, 5'd7, 3, 32'h0,
           1'b1, 32'hCAFE_0001, 4'b0011, 32'h0000_0200, 32'h5678_5678);
    do_mem(4'd5, 32'h0000_0500, 32'h0, 32'h3, 5'd8, 0, 32'h0,
           1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    do_pass(5'd1, 1'b1, 32'h0000_0042, 4'd0, 1'b0);

    // Reset while BUSY: request dropped at once, late ack ignored
    @(posedge clk); #1;
    mem_op_i = 4'd5; mem_addr_i = 32'h0000_0400; wd_i = 5'd4; mem_ack_i = 1'b0;
    clr_exp(); e_stall = 1'b1;
    @(posedge clk); #1;
    clr_exp(); e_stall = 1'b1; e_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    clr_exp(); e_stall = 1'b1; e_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_op_i = 4'd0; wd_i = 5'd2; wreg_i = 1'b1; wdata_i = 32'h55;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    clr_exp();
    e_pass_chk = 1'b1; e_wd = 5'd2; e_wreg = 1'b1; e_wdata_chk = 1'b1; e_wdata = 32'h55;
    e_bus_chk = 1'b1; e_baddr = 32'd0; e_sel = 4'd0; e_we = 1'b0;
    do_pass(5'd2, 1'b1, 32'h66, 4'd0, 1'b0);
    // Counter restarts from zero after reset: full-length timeout again
    do_mem(4'd8, 32'h0000_0600, 32'h1357_9BDF, 32'h7, 5'd10, 0, 32'h0,
           1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    // Word/half at unaligned addresses
    do_mem(4'd5, 32'h0000_0302, 32'h0, 32'h9, 5'd11, 1, 32'h8765_4321,
           1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
    do_mem(4'd4, 32'h0000_0203, 32'h0, 32'h9, 5'd12, 2, 32'h8765_C321,
           1'b0, 32'h0, 4'h0, 32'h0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (m_is_load(op) || m_is_store(op))
        do_mem(op, $urandom, $urandom, $urandom, 5'($urandom), $urandom_range(0, TO + 2),
               $urandom, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
      else
        do_pass(5'($urandom), 1'($urandom), $urandom, op, 1'($urandom));
    end

    @(posedge clk); #1;
    e_on = 1'b0;
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
